// File: rtl/semaforo_scheduler.sv
// -----------------------------------------------------------------------------
// semaforo_scheduler
//
// Cycle-accurate phase scheduler for a two-way intersection (roads A and B)
// with a pedestrian crossing. Green alternates between A and B; a pedestrian
// phase is inserted after the yellow of whichever road is running when a
// button request is pending. Phase durations come from runtime-writable
// configuration registers and take effect at the next load of that phase.
//
// Optional feature macro: SEMAFORO_ALLRED_EN
//   When defined, an all-red clearance phase (CLR_AB / CLR_BA, T_ALLRED
//   cycles) follows each yellow, and the pedestrian decision is taken at the
//   end of the clearance instead of at the end of yellow.
//
// Ports
//   clk       in  1  single clock, all logic on posedge
//   rst       in  1  synchronous active-low reset (0 = reset)
//   bt        in  1  pedestrian button, level, sampled every posedge
//   cfg_we    in  1  configuration write strobe
//   cfg_addr  in  2  0=green A, 1=green B, 2=yellow, 3=pedestrian
//   cfg_data  in  8  duration to write, in cycles (0 behaves as 1)
//   A         out 3  road A lamps {red,yellow,green}, one-hot, registered
//   B         out 3  road B lamps {red,yellow,green}, one-hot, registered
//   walk      out 1  pedestrian walk lamp, registered
//   ped_pend  out 1  pedestrian request latched but not yet served
// -----------------------------------------------------------------------------
module semaforo_scheduler #(
    parameter logic [7:0] T_GREEN_A = 8'd4,
    parameter logic [7:0] T_GREEN_B = 8'd4,
    parameter logic [7:0] T_YELLOW  = 8'd2,
    parameter logic [7:0] T_PED     = 8'd3,
    parameter logic [7:0] T_ALLRED  = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       walk,
    output logic       ped_pend
);

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

`ifdef SEMAFORO_ALLRED_EN
    typedef enum logic [2:0] {
        ST_AG     = 3'd0,
        ST_AY     = 3'd1,
        ST_BG     = 3'd2,
        ST_BY     = 3'd3,
        ST_PED    = 3'd4,
        ST_CLR_AB = 3'd5,
        ST_CLR_BA = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_AG  = 3'd0,
        ST_AY  = 3'd1,
        ST_BG  = 3'd2,
        ST_BY  = 3'd3,
        ST_PED = 3'd4
    } state_t;
`endif

    // Counter value loaded on phase entry. The phase is held while the
    // counter runs down and exits on the edge that sees zero, so a duration
    // of D loads D-1; a duration of 0 is clamped to behave as 1.
    function automatic logic [7:0] load_of(input logic [7:0] dur);
        logic [7:0] val;
        if (dur == 8'd0) begin
            val = 8'd0;
        end else begin
            val = dur - 8'd1;
        end
        return val;
    endfunction

    // Road A lamp pattern for a given phase.
    function automatic logic [2:0] lamp_a(input state_t st);
        logic [2:0] lamp;
        case (st)
            ST_AG:   lamp = LAMP_GREEN;
            ST_AY:   lamp = LAMP_YELLOW;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    // Road B lamp pattern for a given phase.
    function automatic logic [2:0] lamp_b(input state_t st);
        logic [2:0] lamp;
        case (st)
            ST_BG:   lamp = LAMP_GREEN;
            ST_BY:   lamp = LAMP_YELLOW;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    // Configuration registers
    logic [7:0] green_a_r;
    logic [7:0] green_b_r;
    logic [7:0] yellow_r;
    logic [7:0] ped_r;

    // Scheduler state
    state_t     state_r;
    logic [7:0] cnt_r;
    logic       next_road_r;   // 1: road B gets green after PED, 0: road A
    logic       ped_pend_r;
    logic [2:0] a_r;
    logic [2:0] b_r;
    logic       walk_r;

    // Next-state decode
    logic       expired_s;
    state_t     nxt_state_s;
    logic [7:0] ld_val_s;
    logic       enter_ped_s;
    logic       nxt_road_s;

`ifndef SEMAFORO_ALLRED_EN
    // The clearance duration has no consumer in the default build.
    logic unused_allred_s;
    assign unused_allred_s = ^T_ALLRED;
`endif

    // Configuration register file; a write only changes what the next load of
    // that phase picks up, so an active phase keeps its length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            green_a_r <= T_GREEN_A;
            green_b_r <= T_GREEN_B;
            yellow_r  <= T_YELLOW;
            ped_r     <= T_PED;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    green_a_r <= cfg_data;
                2'd1:    green_b_r <= cfg_data;
                2'd2:    yellow_r  <= cfg_data;
                2'd3:    ped_r     <= cfg_data;
                default: green_a_r <= green_a_r;
            endcase
        end else begin
            green_a_r <= green_a_r;
        end
    end

    // Phase transition decode on counter expiry and reload value of the
    // phase being entered.
    always_comb begin
        expired_s   = (cnt_r == 8'd0);
        nxt_state_s = state_r;
        nxt_road_s  = next_road_r;
        ld_val_s    = 8'd0;

        if (expired_s) begin
            case (state_r)
                ST_AG: nxt_state_s = ST_AY;
                ST_BG: nxt_state_s = ST_BY;
`ifdef SEMAFORO_ALLRED_EN
                ST_AY: nxt_state_s = ST_CLR_AB;
                ST_BY: nxt_state_s = ST_CLR_BA;
                ST_CLR_AB: begin
                    if (ped_pend_r) begin
                        nxt_state_s = ST_PED;
                        nxt_road_s  = 1'b1;
                    end else begin
                        nxt_state_s = ST_BG;
                    end
                end
                ST_CLR_BA: begin
                    if (ped_pend_r) begin
                        nxt_state_s = ST_PED;
                        nxt_road_s  = 1'b0;
                    end else begin
                        nxt_state_s = ST_AG;
                    end
                end
`else
                ST_AY: begin
                    if (ped_pend_r) begin
                        nxt_state_s = ST_PED;
                        nxt_road_s  = 1'b1;
                    end else begin
                        nxt_state_s = ST_BG;
                    end
                end
                ST_BY: begin
                    if (ped_pend_r) begin
                        nxt_state_s = ST_PED;
                        nxt_road_s  = 1'b0;
                    end else begin
                        nxt_state_s = ST_AG;
                    end
                end
`endif
                ST_PED: begin
                    if (next_road_r) begin
                        nxt_state_s = ST_BG;
                    end else begin
                        nxt_state_s = ST_AG;
                    end
                end
                default: nxt_state_s = ST_AG;
            endcase
        end else begin
            nxt_state_s = state_r;
        end

        case (nxt_state_s)
            ST_AG:     ld_val_s = load_of(green_a_r);
            ST_BG:     ld_val_s = load_of(green_b_r);
            ST_AY:     ld_val_s = load_of(yellow_r);
            ST_BY:     ld_val_s = load_of(yellow_r);
            ST_PED:    ld_val_s = load_of(ped_r);
`ifdef SEMAFORO_ALLRED_EN
            ST_CLR_AB: ld_val_s = load_of(T_ALLRED);
            ST_CLR_BA: ld_val_s = load_of(T_ALLRED);
`endif
            default:   ld_val_s = 8'd0;
        endcase

        // PED never follows itself, so any expiry landing in PED is an entry.
        enter_ped_s = expired_s && (nxt_state_s == ST_PED);
    end

    // Scheduler FSM: state, phase counter, pedestrian request and the
    // registered lamp outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_AG;
            cnt_r       <= load_of(T_GREEN_A);
            next_road_r <= 1'b0;
            ped_pend_r  <= 1'b0;
            a_r         <= LAMP_GREEN;
            b_r         <= LAMP_RED;
            walk_r      <= 1'b0;
        end else begin
            if (expired_s) begin
                state_r <= nxt_state_s;
                cnt_r   <= ld_val_s;
            end else begin
                state_r <= state_r;
                cnt_r   <= cnt_r - 8'd1;
            end

            next_road_r <= nxt_road_s;

            // Entering PED serves the request and beats a simultaneous press;
            // presses while in PED are ignored so a held button yields one
            // request per visit.
            if (enter_ped_s) begin
                ped_pend_r <= 1'b0;
            end else if (bt && (state_r != ST_PED)) begin
                ped_pend_r <= 1'b1;
            end else begin
                ped_pend_r <= ped_pend_r;
            end

            a_r    <= lamp_a(nxt_state_s);
            b_r    <= lamp_b(nxt_state_s);
            walk_r <= (nxt_state_s == ST_PED);
        end
    end

    assign A        = a_r;
    assign B        = b_r;
    assign walk     = walk_r;
    assign ped_pend = ped_pend_r;

endmodule

// File: tb/tb_semaforo_scheduler.sv
// -----------------------------------------------------------------------------
// tb_semaforo_scheduler
//
// Directed bench for semaforo_scheduler. Each step drives the inputs, pushes
// the expected {A,B,walk,ped_pend} for the coming edge onto a scoreboard queue,
// then pops and compares it #1 after that edge.
// -----------------------------------------------------------------------------
module tb_semaforo_scheduler;

    logic       clk;
    logic       rst;
    logic       bt;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [2:0] A;
    logic [2:0] B;
    logic       walk;
    logic       ped_pend;

    semaforo_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .bt       (bt),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .A        (A),
        .B        (B),
        .walk     (walk),
        .ped_pend (ped_pend)
    );

    localparam int P_AG  = 0;
    localparam int P_AY  = 1;
    localparam int P_BG  = 2;
    localparam int P_BY  = 3;
    localparam int P_PED = 4;
    localparam int P_CLR = 5;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   bad  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {A,B,walk,ped_pend} for a phase, from the lamp table.
    function automatic logic [7:0] expect_of(input int ph, input logic p);
        logic [2:0] ea;
        logic [2:0] eb;
        logic       ew;
        ea = 3'b100;
        eb = 3'b100;
        ew = 1'b0;
        case (ph)
            P_AG:    ea = 3'b001;
            P_AY:    ea = 3'b010;
            P_BG:    eb = 3'b001;
            P_BY:    eb = 3'b010;
            P_PED:   ew = 1'b1;
            default: ew = 1'b0;
        endcase
        return {ea, eb, ew, p};
    endfunction

    // One clock: drive, push expectation, clock, pop and compare.
    task automatic step(input logic bt_v, input logic rst_v, input logic we_v,
                        input logic [1:0] ad, input logic [7:0] dt,
                        input int ph, input logic p, input string tag);
        exp_t e;
        exp_t got;
        logic [7:0] obs;
        bt       = bt_v;
        rst      = rst_v;
        cfg_we   = we_v;
        cfg_addr = ad;
        cfg_data = dt;
        e.v   = expect_of(ph, p);
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        obs = {A, B, walk, ped_pend};
        vecs++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            got = sbq.pop_front();
            assert (obs === got.v) else begin
                bad++;
                $error("FAIL %s: observed A,B,walk,pend=%b expected %b", got.tag, obs, got.v);
            end
        end
    endtask

    task automatic idle(input int ph, input int n, input logic p, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, ph, p, tag);
        end
    endtask

    task automatic held(input int ph, input int n, input logic p, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, ph, p, tag);
        end
    endtask

    task automatic rst_edge(input string tag);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, P_AG, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        bt       = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 8'd0;
        @(negedge clk);

`ifdef SEMAFORO_ALLRED_EN
        // All-red clearance after each yellow; press in BG.
        rst_edge("ar_reset");
        idle(P_AG, 3, 1'b0, "ar_ag");
        idle(P_AY, 2, 1'b0, "ar_ay");
        idle(P_CLR, 1, 1'b0, "ar_clr_ab");
        idle(P_BG, 4, 1'b0, "ar_bg");
        idle(P_BY, 2, 1'b0, "ar_by");
        idle(P_CLR, 1, 1'b0, "ar_clr_ba");
        idle(P_AG, 4, 1'b0, "ar_ag2");
        idle(P_AY, 2, 1'b0, "ar_ay2");
        idle(P_CLR, 1, 1'b0, "ar_clr_ab2");
        step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, P_BG, 1'b1, "ar_bg_press");
        idle(P_BG, 3, 1'b1, "ar_bg_pend");
        idle(P_BY, 2, 1'b1, "ar_by_pend");
        idle(P_CLR, 1, 1'b1, "ar_clr_pend");
        idle(P_PED, 3, 1'b0, "ar_ped");
        idle(P_AG, 4, 1'b0, "ar_ag_after_ped");
`else
        // Idle cycling, two full periods.
        rst_edge("idle_reset");
        idle(P_AG, 3, 1'b0, "idle_ag");
        idle(P_AY, 2, 1'b0, "idle_ay");
        idle(P_BG, 4, 1'b0, "idle_bg");
        idle(P_BY, 2, 1'b0, "idle_by");
        idle(P_AG, 4, 1'b0, "idle_ag2");
        idle(P_AY, 2, 1'b0, "idle_ay2");
        idle(P_BG, 4, 1'b0, "idle_bg2");
        idle(P_BY, 2, 1'b0, "idle_by2");

        // Single press in AG cycle 2: PED after AY, then B green.
        rst_edge("pulse_reset");
        step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, P_AG, 1'b1, "pulse_press");
        idle(P_AG, 2, 1'b1, "pulse_ag");
        idle(P_AY, 2, 1'b1, "pulse_ay");
        idle(P_PED, 3, 1'b0, "pulse_ped");
        idle(P_BG, 4, 1'b0, "pulse_bg");
        idle(P_BY, 2, 1'b0, "pulse_by");
        idle(P_AG, 2, 1'b0, "pulse_ag_back");

        // Button held for 20 edges: one request per PED visit.
        rst_edge("hold_reset");
        held(P_AG, 3, 1'b1, "hold_ag");
        held(P_AY, 2, 1'b1, "hold_ay");
        held(P_PED, 3, 1'b0, "hold_ped1");
        held(P_BG, 1, 1'b0, "hold_bg_exit_ped");
        held(P_BG, 3, 1'b1, "hold_bg_reset");
        held(P_BY, 2, 1'b1, "hold_by");
        held(P_PED, 3, 1'b0, "hold_ped2");
        held(P_AG, 1, 1'b0, "hold_ag_exit_ped");
        held(P_AG, 2, 1'b1, "hold_ag_reset");
        idle(P_AG, 1, 1'b1, "hold_release");
        idle(P_AY, 2, 1'b1, "hold_ay2");

        // Green A reconfiguration: 6 from the next AG, then 0 behaves as 1.
        rst_edge("cfg_reset");
        step(1'b0, 1'b1, 1'b1, 2'd0, 8'd6, P_AG, 1'b0, "cfg_write6");
        idle(P_AG, 2, 1'b0, "cfg_ag_old");
        idle(P_AY, 2, 1'b0, "cfg_ay");
        idle(P_BG, 4, 1'b0, "cfg_bg");
        idle(P_BY, 2, 1'b0, "cfg_by");
        idle(P_AG, 1, 1'b0, "cfg_ag6");
        step(1'b0, 1'b1, 1'b1, 2'd0, 8'd0, P_AG, 1'b0, "cfg_write0");
        idle(P_AG, 4, 1'b0, "cfg_ag6_tail");
        idle(P_AY, 2, 1'b0, "cfg_ay2");
        idle(P_BG, 4, 1'b0, "cfg_bg2");
        idle(P_BY, 2, 1'b0, "cfg_by2");
        idle(P_AG, 1, 1'b0, "cfg_ag0");
        idle(P_AY, 2, 1'b0, "cfg_ay3");
        idle(P_BG, 1, 1'b0, "cfg_bg3");

        // Reset during PED with button pressed: AG, durations back to default.
        rst_edge("mid_reset0");
        step(1'b1, 1'b1, 1'b1, 2'd0, 8'd2, P_AG, 1'b1, "mid_press_write2");
        idle(P_AG, 2, 1'b1, "mid_ag");
        idle(P_AY, 2, 1'b1, "mid_ay");
        idle(P_PED, 2, 1'b0, "mid_ped");
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, P_AG, 1'b0, "mid_reset_in_ped");
        idle(P_AG, 3, 1'b0, "mid_ag_default");
        idle(P_AY, 2, 1'b0, "mid_ay_after");
        idle(P_BG, 1, 1'b0, "mid_bg_after");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
